// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared types and constants for the memory access controller.
//   state_t     - access sequencer states
//   MMIO_ADDR   - CPU address decoded as switches/hex register when the
//                 MMIO_SWITCH_HEX_EN build option is enabled
//   SRAM_AW_DEF - default SRAM address width
//   CNT_W       - wait-state down-counter width (WAIT_STATES <= 15)
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [15:0] MMIO_ADDR   = 16'hFFFF;
    localparam int          SRAM_AW_DEF = 20;
    localparam int          CNT_W       = 4;

endpackage

// File: rtl/mem_access_ctrl_mmio_regs.sv
// mmio_regs: memory-mapped switch/hex register decode.
//   i_clk, i_reset  - clock and synchronous active-high reset
//   i_addr          - latched access address
//   i_wdata         - latched write data
//   i_switches      - board switches (read source at MMIO_ADDR)
//   i_sram_rd       - SRAM read data (read source elsewhere)
//   i_commit        - write completes this edge (entry to DONE)
//   o_hit           - latched address equals MMIO_ADDR
//   o_rd_data       - read data selected for the MDR path
//   o_hex_data      - hex display register
// Only instantiated when MMIO_SWITCH_HEX_EN is defined.
module mmio_regs
    import mem_ctrl_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [15:0] i_addr,
    input  logic [15:0] i_wdata,
    input  logic [15:0] i_switches,
    input  logic [15:0] i_sram_rd,
    input  logic        i_commit,
    output logic        o_hit,
    output logic [15:0] o_rd_data,
    output logic [15:0] o_hex_data
);

    logic [15:0] r_hex;

    assign o_hit      = (i_addr == MMIO_ADDR);
    assign o_rd_data  = o_hit ? i_switches : i_sram_rd;
    assign o_hex_data = r_hex;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_hex <= '0;
        end else if (i_commit && o_hit) begin
            r_hex <= i_wdata;
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences asynchronous SRAM strobes for one CPU word
// access (SETUP, WAIT_STATES cycles of ACCESS, DONE) and returns read data
// to the MDR path with a one-cycle Ready pulse.
//   Clk, Reset            - clock, synchronous active-high reset
//   Req, Wr               - request (level, sampled in IDLE), 1 = write
//   ADDR, Data_from_CPU   - address from MAR, write data from MDR
//   Data_to_CPU           - registered read data
//   Ready, Busy           - completion pulse, non-IDLE indicator
//   SRAM_*                - SRAM address, data pad and active-low strobes
//   Switches, HEX_DATA    - MMIO read source / write target
// Build option: MMIO_SWITCH_HEX_EN maps address 16'hFFFF to Switches
// (read) and HEX_DATA (write); otherwise HEX_DATA is constant 0.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 2,
    parameter int unsigned SRAM_AW     = SRAM_AW_DEF
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Req,
    input  logic               Wr,
    input  logic [15:0]        ADDR,
    input  logic [15:0]        Data_from_CPU,
    output logic [15:0]        Data_to_CPU,
    output logic               Ready,
    output logic               Busy,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic [15:0]        SRAM_DQ_out,
    output logic               SRAM_DQ_oe,
    input  logic [15:0]        SRAM_DQ_in,
    output logic               SRAM_CE_N,
    output logic               SRAM_OE_N,
    output logic               SRAM_WE_N,
    output logic               SRAM_UB_N,
    output logic               SRAM_LB_N,
    input  logic [15:0]        Switches,
    output logic [15:0]        HEX_DATA
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_STATES - 1);

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [15:0]        r_addr;
    logic               r_wr;
    logic [15:0]        r_wdata;
    logic [SRAM_AW-1:0] r_sram_addr;
    logic [15:0]        r_rd_data;
    logic               w_last;
    logic               w_mmio;
    logic [15:0]        w_rd_src;

    // Final ACCESS cycle: the next edge enters DONE.
    assign w_last = (r_state == ACCESS) && (r_cnt == '0);

`ifdef MMIO_SWITCH_HEX_EN
    mmio_regs u_mmio (
        .i_clk      (Clk),
        .i_reset    (Reset),
        .i_addr     (r_addr),
        .i_wdata    (r_wdata),
        .i_switches (Switches),
        .i_sram_rd  (SRAM_DQ_in),
        .i_commit   (w_last && r_wr),
        .o_hit      (w_mmio),
        .o_rd_data  (w_rd_src),
        .o_hex_data (HEX_DATA)
    );
`else
    logic w_unused_switches;
    assign w_unused_switches = ^Switches;
    assign w_mmio            = 1'b0;
    assign w_rd_src          = SRAM_DQ_in;
    assign HEX_DATA          = '0;
`endif

    assign Data_to_CPU = r_rd_data;
    assign SRAM_ADDR   = r_sram_addr;
    assign SRAM_DQ_out = r_wdata;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_wr        <= 1'b0;
            r_wdata     <= '0;
            r_sram_addr <= '0;
            r_rd_data   <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (Req) begin
                        r_addr      <= ADDR;
                        r_wr        <= Wr;
                        r_wdata     <= Data_from_CPU;
                        r_sram_addr <= {{(SRAM_AW-16){1'b0}}, ADDR};
                    end
                end
                SETUP:   r_cnt <= CNT_LOAD;
                ACCESS: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
            if (w_last && !r_wr) begin
                r_rd_data <= w_rd_src;
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        SRAM_CE_N  = 1'b1;
        SRAM_OE_N  = 1'b1;
        SRAM_WE_N  = 1'b1;
        SRAM_UB_N  = 1'b1;
        SRAM_LB_N  = 1'b1;
        SRAM_DQ_oe = 1'b0;
        Ready      = 1'b0;
        Busy       = 1'b0;
        case (r_state)
            IDLE: begin
                if (Req) begin
                    w_next = SETUP;
                end
            end
            SETUP: begin
                Busy      = 1'b1;
                SRAM_UB_N = 1'b0;
                SRAM_LB_N = 1'b0;
                if (!w_mmio) begin
                    SRAM_CE_N  = 1'b0;
                    SRAM_DQ_oe = r_wr;
                end
                w_next = ACCESS;
            end
            ACCESS: begin
                Busy      = 1'b1;
                SRAM_UB_N = 1'b0;
                SRAM_LB_N = 1'b0;
                if (!w_mmio) begin
                    SRAM_CE_N  = 1'b0;
                    SRAM_OE_N  = r_wr;
                    SRAM_WE_N  = !r_wr;
                    SRAM_DQ_oe = r_wr;
                end
                if (r_cnt == '0) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                Busy      = 1'b1;
                Ready     = 1'b1;
                SRAM_UB_N = 1'b0;
                SRAM_LB_N = 1'b0;
                // CE and DQ held through DONE for write hold time.
                if (!w_mmio) begin
                    SRAM_CE_N  = 1'b0;
                    SRAM_DQ_oe = r_wr;
                end
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Memory-side stage directly downstream of the MAR/MDR registers.
- Takes a read/write request from the control unit, with the address from MAR and write data from MDR.
- Sequences the asynchronous SRAM strobes with a fixed number of wait states, then returns read data to the MDR input path with a one-cycle Ready pulse.
- Optionally decodes one memory-mapped I/O address (switches / hex display).

Parameters:
- WAIT_STATES, 2, cycles of active OE_N/WE_N strobe; legal range 1..15.
- SRAM_AW, 20, SRAM address width; the 16-bit CPU address is zero-extended to this width.

Ports:
- Clk  in  1  system clock, all logic on rising edge
- Reset  in  1  synchronous, active-high reset
- Req  in  1  access request, level; sampled only in IDLE
- Wr  in  1  1 = write, 0 = read; sampled with Req
- ADDR  in  16  address from MAR
- Data_from_CPU  in  16  write data from MDR
- Data_to_CPU  out  16  registered read data to MDR mux
- Ready  out  1  one-cycle pulse when access completes
- Busy  out  1  high in every non-IDLE state
- SRAM_ADDR  out  SRAM_AW  registered, zero-extended address
- SRAM_DQ_out  out  16  write data to pad
- SRAM_DQ_oe  out  1  pad output enable
- SRAM_DQ_in  in  16  read data from pad
- SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N  out  1 each  active-low SRAM controls
- Switches  in  16  board switches (MMIO read source)
- HEX_DATA  out  16  hex display register (MMIO write target)

Behaviour:
- Reset values:
  - State = IDLE.
  - Data_to_CPU, SRAM_ADDR, SRAM_DQ_out, HEX_DATA = 0.
  - Ready, Busy, SRAM_DQ_oe = 0.
  - All *_N strobes = 1.
- Reset mid-operation aborts at the next edge: strobes deassert and the DQ pad is released in that same cycle. No partial write is committed to HEX_DATA.
- FSM states:
  - IDLE: if Req=1, latch ADDR, Wr and Data_from_CPU into internal registers, then go to SETUP; otherwise stay.
  - SETUP (1 cycle): SRAM_ADDR valid; CE_N=UB_N=LB_N=0; OE_N=WE_N=1; SRAM_DQ_oe=1 if write.
  - ACCESS (WAIT_STATES cycles, down-counter): read drives OE_N=0; write drives WE_N=0 with DQ driven.
  - DONE (1 cycle): OE_N=WE_N=1, CE_N held at 0; DQ still driven on write (hold time).
    - Read: Data_to_CPU <= SRAM_DQ_in, captured on the ACCESS->DONE edge.
    - Ready=1 in this cycle.
  - DONE always goes to IDLE.
- Latency: Req sampled at edge 0 -> Ready high in cycle WAIT_STATES+2 -> back in IDLE the cycle after. Default WAIT_STATES=2 gives Ready 4 cycles after acceptance.
- Request handling:
  - Req is ignored outside IDLE.
  - If Req is still high when IDLE is re-entered, a new access starts (back-to-back, one IDLE cycle between accesses).
  - The requester must drop Req on Ready to avoid a repeat access.
- Data_to_CPU holds its value until the next read completes; writes do not change it.
- Address/data are registered at acceptance; changes on ADDR or Data_from_CPU mid-access have no effect.
- UB_N/LB_N are always 0 during an access (word access only).

Optional Feature:
- Macro: MMIO_SWITCH_HEX_EN.
- Defined: address 16'hFFFF is MMIO.
  - CE_N, OE_N and WE_N stay at 1 for the whole access and DQ_oe stays 0. Timing is identical to an SRAM access.
  - Read: Data_to_CPU <= Switches, captured on the ACCESS->DONE edge.
  - Write: HEX_DATA <= latched data on entry to DONE.
- Undefined: 16'hFFFF is an ordinary SRAM address; Switches is ignored; HEX_DATA is constant 0.

Decomposition:
- Package mem_ctrl_pkg contains:
  - state enum (IDLE, SETUP, ACCESS, DONE)
  - MMIO_ADDR = 16'hFFFF
  - SRAM_AW default
  - wait-counter width localparam (4 bits)
- One sub-module, mmio_regs: address match, switch read mux, and HEX_DATA register. It is instantiated only under MMIO_SWITCH_HEX_EN.

Test Plan:
- Reset, then read of 16'h3000 with SRAM_DQ_in=16'hBEEF, WAIT_STATES=2:
  - SRAM_ADDR=20'h03000; OE_N low for exactly 2 cycles.
  - Ready pulses in cycle 4 after acceptance; Data_to_CPU=16'hBEEF.
- Write 16'h1234 to 16'h0042:
  - WE_N low for exactly 2 cycles, DQ_oe=1 from SETUP through DONE, SRAM_DQ_out=16'h1234.
  - OE_N never low; Data_to_CPU unchanged.
- Req held high across Ready:
  - Two consecutive reads with exactly one IDLE cycle between DONE and the next SETUP.
  - ADDR changed during ACCESS does not alter SRAM_ADDR.
- Reset asserted in the first ACCESS cycle of a write:
  - Next cycle: WE_N=1, CE_N=1, DQ_oe=0, Busy=0, Ready never pulses.
- With MMIO_SWITCH_HEX_EN:
  - Write 16'h00A5 to 16'hFFFF: HEX_DATA=16'h00A5, CE_N stays 1.
  - Read 16'hFFFF with Switches=16'h0F0F: Data_to_CPU=16'h0F0F.
  - Without the macro, the same read drives CE_N/OE_N low and returns SRAM_DQ_in.
